// File: rtl/four_digit_sevenseg_scanner_if.sv
// rtl/four_digit_sevenseg_scanner_if.sv - display data in, multiplexed anode/segment drive out
interface four_digit_sevenseg_scanner_if;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value, digit_en, dp_in,
        input  an, seg, dp
    );

    modport slave (
        input  value, digit_en, dp_in,
        output an, seg, dp
    );
endinterface

// File: rtl/four_digit_sevenseg_scanner.sv
// rtl/four_digit_sevenseg_scanner.sv - 4-digit common-anode 7-seg scanner with dead-time blanking
// Optional leading-zero suppression: SCAN_LEADING_ZERO_BLANK_EN
module four_digit_sevenseg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    four_digit_sevenseg_scanner_if.slave    bus
);

    localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          last;
    logic [3:0]    cur_nib;
    logic          cur_en;
    logic          cur_dp;
    logic          lead_zero;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign last = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == SHOW_LAST);

    // Digit 0 lives in the top nibble and is shown on the leftmost anode.
    always_comb begin
        cur_nib = 4'h0;
        case (idx_q)
            2'd0:    cur_nib = bus.value[15:12];
            2'd1:    cur_nib = bus.value[11:8];
            2'd2:    cur_nib = bus.value[7:4];
            default: cur_nib = bus.value[3:0];
        endcase
    end

    assign cur_en = bus.digit_en[idx_q];
    assign cur_dp = bus.dp_in[idx_q];

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd0:    lead_zero = (bus.value[15:12] == 4'h0);
            2'd1:    lead_zero = (bus.value[15:8] == 8'h00);
            2'd2:    lead_zero = (bus.value[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (last) begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                idx_d   = idx_q + 2'd1;
            end
        end
    end

    // Inputs are captured only on the BLANK->SHOW edge; the registered
    // outputs then hold the digit steady for the whole slot.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (last && state_q == ST_BLANK) begin
            if (!cur_en) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else if (lead_zero) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = ~cur_dp;
            end else begin
                an_d  = ~(4'b1000 >> idx_q);
                seg_d = decode(cur_nib);
                dp_d  = ~cur_dp;
            end
        end else if (last && state_q == ST_SHOW) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
